// File: rtl/spi_ram_pkg.sv
// Shared constants for the SPI-to-RAM command controller: command codes,
// FSM state encodings and payload width.
package spi_ram_pkg;

  localparam int PAYLOAD_W = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITE     = 2'd1;
  localparam logic [1:0] ST_READ_REQ  = 2'd2;
  localparam logic [1:0] ST_READ_WAIT = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    WRITE     = ST_WRITE,
    READ_REQ  = ST_READ_REQ,
    READ_WAIT = ST_READ_WAIT
  } state_t;

endpackage

// File: rtl/spi_ram_ctrl.sv
// Decodes 10-bit SPI words into RAM address loads, writes and reads; one access
// in flight at a time, read data returned 2 clocks after the command edge.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [9:0]           rx_data,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 busy,
  output logic                 err
);

  state_t               state;
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic                 rd_armed;
  logic [1:0]           cmd;
  logic [PAYLOAD_W-1:0] payload;

  assign cmd     = rx_data[9:8];
  assign payload = rx_data[PAYLOAD_W-1:0];

  // Pointers wrap silently from the last RAM word back to 0.
  function automatic logic [ADDR_SIZE-1:0] ptr_next(input logic [ADDR_SIZE-1:0] p);
    return (p == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : p + ADDR_SIZE'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_armed  <= 1'b0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err      <= 1'b0;
      tx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            case (cmd)
              CMD_WR_ADDR: wr_ptr <= ADDR_SIZE'(payload);
              CMD_WR_DATA: begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= wr_ptr;
                mem_wdata <= payload;
                busy      <= 1'b1;
                state     <= WRITE;
              end
              CMD_RD_ADDR: begin
                rd_ptr   <= ADDR_SIZE'(payload);
                rd_armed <= 1'b1;
              end
              default: begin
                if (rd_armed) begin
                  mem_en   <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= rd_ptr;
                  busy     <= 1'b1;
                  state    <= READ_REQ;
                end else begin
                  err <= 1'b1;
                end
              end
            endcase
          end
        end
        WRITE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          busy   <= 1'b0;
          wr_ptr <= ptr_next(wr_ptr);
          state  <= IDLE;
        end
        READ_REQ: begin
          mem_en <= 1'b0;
          rd_ptr <= ptr_next(rd_ptr);
          state  <= READ_WAIT;
        end
        READ_WAIT: begin
          tx_data  <= mem_rdata;
          tx_valid <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A word arriving mid-access is discarded; the access itself carries on.
      if (rx_valid && state != IDLE) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: vector table of SPI words with a
// RAM access / read-data scoreboard, plus drop and mid-read reset sequences.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [9:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  // Synchronous single-port RAM: read data appears one clock after the enable edge.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } acc_t;

  typedef struct {
    logic [9:0] word;
    int         n_en;
    int         n_err;
    int         n_busy;
    int         n_tx;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    string      name;
  } vec_t;

  acc_t       acc_q[$];
  logic [7:0] tx_q[$];
  vec_t       vecs[13];

  int checks   = 0;
  int failures = 0;
  int n_en, n_err, n_busy, n_tx, cyc, tx_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic clr();
    n_en = 0; n_err = 0; n_busy = 0; n_tx = 0; cyc = 0; tx_idx = -1;
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic cycle();
    acc_t a;
    @(posedge clk);
    #1;
    if (mem_en) begin
      n_en++;
      if (acc_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_access actual=we%0d/addr0x%0h required=none", mem_we, mem_addr);
      end else begin
        a = acc_q.pop_front();
        check("acc_we", 32'(mem_we), 32'(a.we));
        check("acc_addr", 32'(mem_addr), 32'(a.addr));
        if (a.we) check("acc_wdata", 32'(mem_wdata), 32'(a.wdata));
      end
    end
    if (tx_valid) begin
      n_tx++;
      if (tx_idx < 0) tx_idx = cyc;
      if (tx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tx actual=0x%0h required=none", tx_data);
      end else begin
        check("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
      end
    end
    if (err)  n_err++;
    if (busy) n_busy++;
    cyc++;
  endtask

  task automatic send(input logic [9:0] word);
    rx_data  = word;
    rx_valid = 1'b1;
    cycle();
    rx_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    clr();
    if (v.n_en > 0) acc_q.push_back('{we: v.we, addr: v.addr, wdata: v.wdata});
    if (v.n_tx > 0) tx_q.push_back(v.rdata);
    send(v.word);
    repeat (4) cycle();
    check({v.name, "_en_cycles"}, n_en, v.n_en);
    check({v.name, "_err_cycles"}, n_err, v.n_err);
    check({v.name, "_busy_cycles"}, n_busy, v.n_busy);
    check({v.name, "_tx_count"}, n_tx, v.n_tx);
    if (v.n_tx > 0) begin
      check({v.name, "_tx_latency"}, tx_idx, 2);
      check({v.name, "_tx_hold"}, 32'(tx_data), 32'(v.rdata));
    end
    check({v.name, "_acc_pending"}, acc_q.size(), 0);
    check({v.name, "_tx_pending"}, tx_q.size(), 0);
  endtask

  initial begin
    //           word     en err busy tx we addr   wdata  rdata
    vecs[0]  = '{10'h300, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, "rd_unarmed"};
    vecs[1]  = '{10'h010, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, "wr_addr_10"};
    vecs[2]  = '{10'h1A5, 1, 0, 1, 0, 1, 8'h10, 8'hA5, 8'h00, "wr_a5"};
    vecs[3]  = '{10'h13C, 1, 0, 1, 0, 1, 8'h11, 8'h3C, 8'h00, "wr_3c"};
    vecs[4]  = '{10'h210, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, "rd_addr_10"};
    vecs[5]  = '{10'h300, 1, 0, 2, 1, 0, 8'h10, 8'h00, 8'hA5, "rd_a5"};
    vecs[6]  = '{10'h300, 1, 0, 2, 1, 0, 8'h11, 8'h00, 8'h3C, "rd_stream"};
    vecs[7]  = '{10'h0FF, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, "wr_addr_ff"};
    vecs[8]  = '{10'h111, 1, 0, 1, 0, 1, 8'hFF, 8'h11, 8'h00, "wr_ff"};
    vecs[9]  = '{10'h122, 1, 0, 1, 0, 1, 8'h00, 8'h22, 8'h00, "wr_wrap"};
    vecs[10] = '{10'h2FF, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, "rd_addr_ff"};
    vecs[11] = '{10'h300, 1, 0, 2, 1, 0, 8'hFF, 8'h00, 8'h11, "rd_ff"};
    vecs[12] = '{10'h300, 1, 0, 2, 1, 0, 8'h00, 8'h00, 8'h22, "rd_wrap"};

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          32'({tx_data, tx_valid, mem_en, mem_we, mem_addr, mem_wdata, busy, err}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Second word lands in READ_REQ: dropped with err, first read completes once.
    send(10'h210);
    repeat (4) cycle();
    clr();
    acc_q.push_back('{we: 1'b0, addr: 8'h10, wdata: 8'h00});
    tx_q.push_back(8'hA5);
    rx_data  = 10'h300;
    rx_valid = 1'b1;
    cycle();
    rx_data  = 10'h1FF;
    cycle();
    rx_valid = 1'b0;
    repeat (4) cycle();
    check("drop_en_cycles", n_en, 1);
    check("drop_err_cycles", n_err, 1);
    check("drop_tx_count", n_tx, 1);
    check("drop_tx_latency", tx_idx, 2);
    check("drop_busy_cycles", n_busy, 2);
    check("drop_acc_pending", acc_q.size(), 0);
    run_vec('{10'h300, 1, 0, 2, 1, 0, 8'h11, 8'h00, 8'h3C, "after_drop"});

    // Reset while in READ_WAIT: outputs clear at once, the read never returns.
    send(10'h212);
    repeat (4) cycle();
    clr();
    acc_q.push_back('{we: 1'b0, addr: 8'h12, wdata: 8'h00});
    send(10'h300);
    cycle();
    check("mid_read_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_read_rst_outputs",
          32'({tx_data, tx_valid, mem_en, mem_we, mem_addr, mem_wdata, busy, err}), 32'd0);
    rx_data  = 10'h2AA;
    rx_valid = 1'b1;
    cycle();
    rx_valid = 1'b0;
    cycle();
    rst = 1'b0;
    repeat (3) cycle();
    check("mid_read_tx_count", n_tx, 0);
    check("mid_read_acc_pending", acc_q.size(), 0);
    run_vec('{10'h300, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, "rd_after_rst"});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
